// File: rtl/ysyx_25030093_csr_file_if.sv
// Request/response bundle between the retire stage and the machine-mode CSR file.
// Valid/ready semantics: in_valid qualifies every request field in the same cycle; there is
// no ready because the CSR file accepts one request per cycle unconditionally. The response
// fields (csr_rdata, redirect_pc, illegal) are combinational and valid whenever inputs are stable.
interface ysyx_25030093_csr_file_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_src;
  logic [XLEN-1:0] csr_rdata;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_tval;
  logic            mret;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;

  modport master (
    output in_valid, csr_addr, csr_op, csr_src,
    output trap_req, trap_cause, trap_pc, trap_tval, mret,
    input  csr_rdata, redirect_pc, illegal
  );

  modport slave (
    input  in_valid, csr_addr, csr_op, csr_src,
    input  trap_req, trap_cause, trap_pc, trap_tval, mret,
    output csr_rdata, redirect_pc, illegal
  );
endinterface

// File: rtl/ysyx_25030093_csr_file.sv
// Machine-mode CSR file: Zicsr RMW, trap entry / mret with MIE/MPIE stacking, 64-bit counters.
// Optional minstret/minstreth counter is enabled by defining YSYX_25030093_MINSTRET_EN.
module ysyx_25030093_csr_file #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] VENDOR_ID   = 32'h79737978,
  parameter logic [31:0] ARCH_ID     = 32'd25030093,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_25030093_csr_file_if.slave   bus
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Architectural state
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
`ifdef YSYX_25030093_MINSTRET_EN
  logic [63:0]     minstret_q, minstret_d;
`endif

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] old_val;
  logic            mapped;
  logic            read_only;
  logic            wr_attempt;
  logic            illegal;
  logic [XLEN-1:0] wdata;
  logic            do_trap;
  logic            do_mret;
  logic            do_write;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] redirect_pc;

  // MPP is hardwired to M-mode; only MIE and MPIE are storage.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    old_val   = '0;
    mapped    = 1'b0;
    read_only = 1'b0;
    case (bus.csr_addr)
      ADDR_MSTATUS:   begin mapped = 1'b1; old_val = mstatus_rd;       end
      ADDR_MTVEC:     begin mapped = 1'b1; old_val = mtvec_q;          end
      ADDR_MSCRATCH:  begin mapped = 1'b1; old_val = mscratch_q;       end
      ADDR_MEPC:      begin mapped = 1'b1; old_val = mepc_q;           end
      ADDR_MCAUSE:    begin mapped = 1'b1; old_val = mcause_q;         end
      ADDR_MTVAL:     begin mapped = 1'b1; old_val = mtval_q;          end
      ADDR_MCYCLE:    begin mapped = 1'b1; old_val = mcycle_q[31:0];   end
      ADDR_MCYCLEH:   begin mapped = 1'b1; old_val = mcycle_q[63:32];  end
`ifdef YSYX_25030093_MINSTRET_EN
      ADDR_MINSTRET:  begin mapped = 1'b1; old_val = minstret_q[31:0];  end
      ADDR_MINSTRETH: begin mapped = 1'b1; old_val = minstret_q[63:32]; end
`endif
      ADDR_MVENDORID: begin mapped = 1'b1; read_only = 1'b1; old_val = VENDOR_ID; end
      ADDR_MARCHID:   begin mapped = 1'b1; read_only = 1'b1; old_val = ARCH_ID;   end
      default:        ;
    endcase
  end

  // RS/RC with a zero source is a pure read and must not count as a write attempt.
  always_comb begin
    wr_attempt = 1'b0;
    wdata      = bus.csr_src;
    case (bus.csr_op)
      OP_RW: begin wr_attempt = 1'b1;                  wdata = bus.csr_src;            end
      OP_RS: begin wr_attempt = (bus.csr_src != '0);   wdata = old_val | bus.csr_src;  end
      OP_RC: begin wr_attempt = (bus.csr_src != '0);   wdata = old_val & ~bus.csr_src; end
      default: ;
    endcase
  end

  assign illegal  = (bus.csr_op != OP_NONE) & (~mapped | (read_only & wr_attempt));
  assign do_trap  = bus.in_valid & bus.trap_req;
  assign do_mret  = bus.in_valid & ~bus.trap_req & bus.mret;
  assign do_write = bus.in_valid & ~bus.trap_req & ~bus.mret & wr_attempt & ~illegal;

  assign tvec_base = mtvec_q & ~32'h3;

  always_comb begin
    redirect_pc = mepc_q;
    if (bus.trap_req) begin
      if (mtvec_q[0] && bus.trap_cause[XLEN-1]) begin
        redirect_pc = tvec_base + {bus.trap_cause[XLEN-3:0], 2'b00};
      end else begin
        redirect_pc = tvec_base;
      end
    end
  end

  assign bus.csr_rdata   = old_val;
  assign bus.illegal     = illegal;
  assign bus.redirect_pc = redirect_pc;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (do_trap) begin
      mepc_d   = bus.trap_pc & ~32'h3;
      mcause_d = bus.trap_cause;
      mtval_d  = bus.trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_write) begin
      case (bus.csr_addr)
        ADDR_MSTATUS:  begin mie_d = wdata[3]; mpie_d = wdata[7]; end
        ADDR_MTVEC:    mtvec_d    = wdata & ~32'h2;
        ADDR_MSCRATCH: mscratch_d = wdata;
        ADDR_MEPC:     mepc_d     = wdata & ~32'h3;
        ADDR_MCAUSE:   mcause_d   = wdata;
        ADDR_MTVAL:    mtval_d    = wdata;
        default:       ;
      endcase
    end
  end

  // A write to either half replaces it and suppresses this cycle's increment.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (do_write && bus.csr_addr == ADDR_MCYCLE) begin
      mcycle_d = {mcycle_q[63:32], wdata};
    end else if (do_write && bus.csr_addr == ADDR_MCYCLEH) begin
      mcycle_d = {wdata, mcycle_q[31:0]};
    end
  end

`ifdef YSYX_25030093_MINSTRET_EN
  always_comb begin
    minstret_d = minstret_q;
    if (do_write && bus.csr_addr == ADDR_MINSTRET) begin
      minstret_d = {minstret_q[63:32], wdata};
    end else if (do_write && bus.csr_addr == ADDR_MINSTRETH) begin
      minstret_d = {wdata, minstret_q[31:0]};
    end else if (bus.in_valid && !bus.trap_req) begin
      minstret_d = minstret_q + 64'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'h2;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
    end
  end

`ifdef YSYX_25030093_MINSTRET_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      minstret_q <= '0;
    end else begin
      minstret_q <= minstret_d;
    end
  end
`endif

endmodule
